// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Opcode encodings, default latencies and counter sizing.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic int mdu_cnt_w(input int m, input int d);
        return $clog2(((m > d) ? m : d) + 1);
    endfunction

    localparam int MDU_CNT_W = mdu_cnt_w(MDU_MULT_CYCLES, MDU_DIV_CYCLES);

endpackage

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/DIV unit holding HI/LO.
// Result is computed at issue and committed when the busy counter expires.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = mdu_cnt_w(MULT_CYCLES, DIV_CYCLES);

    logic [CW-1:0] cnt;
    logic [31:0]   pend_hi;
    logic [31:0]   pend_lo;
    logic          pend_wr;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] ua, ub, ub_nz, b_nz;
    logic [31:0] sq, sr, uq, ur;
    logic [31:0] res_hi, res_lo;
    logic [CW-1:0] res_cnt;
    logic        is_arith;
    logic        dz;

    assign Busy = (cnt != '0);
    assign dz   = (B == 32'd0);

    always_comb begin
        prod_s = $signed(A) * $signed(B);
        prod_u = {32'd0, A} * {32'd0, B};
        // Divisor forced non-zero; divide-by-zero results are never committed.
        b_nz  = dz ? 32'd1 : B;
        ua    = A[31] ? (32'd0 - A) : A;
        ub    = B[31] ? (32'd0 - B) : B;
        ub_nz = dz ? 32'd1 : ub;
        sq    = ua / ub_nz;
        sr    = ua % ub_nz;
        uq    = A / b_nz;
        ur    = A % b_nz;
    end

    always_comb begin
        res_hi   = 32'd0;
        res_lo   = 32'd0;
        res_cnt  = '0;
        is_arith = 1'b0;
        case (MDUOp)
            MDU_MULT: begin
                res_hi   = prod_s[63:32];
                res_lo   = prod_s[31:0];
                res_cnt  = CW'(MULT_CYCLES);
                is_arith = 1'b1;
            end
            MDU_MULTU: begin
                res_hi   = prod_u[63:32];
                res_lo   = prod_u[31:0];
                res_cnt  = CW'(MULT_CYCLES);
                is_arith = 1'b1;
            end
            MDU_DIV: begin
                res_lo   = (A[31] ^ B[31]) ? (32'd0 - sq) : sq;
                res_hi   = A[31] ? (32'd0 - sr) : sr;
                res_cnt  = CW'(DIV_CYCLES);
                is_arith = 1'b1;
            end
            MDU_DIVU: begin
                res_lo   = uq;
                res_hi   = ur;
                res_cnt  = CW'(DIV_CYCLES);
                is_arith = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else if (Busy) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1) && pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else if (Start) begin
            if (is_arith) begin
                cnt     <= res_cnt;
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= !(dz && (MDUOp == MDU_DIV || MDUOp == MDU_DIVU));
            end else if (MDUOp == MDU_MTHI) begin
                HI <= A;
            end else if (MDUOp == MDU_MTLO) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_mdu_hilo;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDUOp = 3'd7;
        A     = 32'hDEADBEEF;
        B     = 32'h0BADF00D;
    endtask

    // Issue, check Busy for n cycles with HI/LO held, then check the commit.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] phi, input logic [31:0] plo,
                          input logic [31:0] ehi, input logic [31:0] elo);
        issue(op, a, b);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
            chk({tag, "_hold_hi"}, HI, phi);
            chk({tag, "_hold_lo"}, LO, plo);
            tick();
        end
        chk({tag, "_done"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_hi"}, HI, ehi);
        chk({tag, "_lo"}, LO, elo);
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        tick();
        tick();
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        reset = 1'b0;
        tick();

        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 5,
               32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 5,
               32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000002, 32'hFFFFFFFA);
        run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 10,
               32'h00000002, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd3);
        run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10,
               32'd1, 32'd3, 32'd0, 32'h80000000);

        issue(3'd4, 32'h11, 32'd0);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        chk("mthi_hi", HI, 32'h11);
        chk("mthi_lo", LO, 32'h80000000);
        issue(3'd5, 32'h22, 32'd0);
        chk("mtlo_busy", {31'd0, Busy}, 32'd0);
        chk("mtlo_hi", HI, 32'h11);
        chk("mtlo_lo", LO, 32'h22);

        run_op("div0", 3'd2, 32'd5, 32'd0, 10,
               32'h11, 32'h22, 32'h11, 32'h22);
        run_op("divu0", 3'd3, 32'd9, 32'd0, 10,
               32'h11, 32'h22, 32'h11, 32'h22);

        issue(3'd6, 32'h55, 32'h66);
        chk("rsv_busy", {31'd0, Busy}, 32'd0);
        chk("rsv_hi", HI, 32'h11);
        chk("rsv_lo", LO, 32'h22);

        // MULT 3*4, with a second MULT offered at busy cycle 3.
        issue(3'd0, 32'd3, 32'd4);
        tick();
        tick();
        chk("ign_busy3", {31'd0, Busy}, 32'd1);
        issue(3'd0, 32'd100, 32'd100);
        chk("ign_busy4", {31'd0, Busy}, 32'd1);
        chk("ign_hold_lo", LO, 32'h22);
        tick();
        chk("ign_busy5", {31'd0, Busy}, 32'd1);
        tick();
        chk("ign_done", {31'd0, Busy}, 32'd0);
        chk("ign_hi", HI, 32'd0);
        chk("ign_lo", LO, 32'd12);
        tick();
        chk("ign_norestart", {31'd0, Busy}, 32'd0);
        chk("ign_lo_kept", LO, 32'd12);

        // DIVU 100/7 aborted by reset mid-flight.
        issue(3'd3, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        chk("rst_mid_busy4", {31'd0, Busy}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'd0, Busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_busy", {31'd0, Busy}, 32'd0);
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("post_rst_lo", LO, 32'd0);

        run_op("mult_after", 3'd0, 32'd6, 32'd7, 5,
               32'd0, 32'd0, 32'd0, 32'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
